// File: rtl/scandoubler_zx_if.sv
// Video bus for the ZX scandoubler: ULA-rate inputs and registered VGA-rate outputs.
interface scandoubler_zx_if;
  logic       HSync;
  logic       VSync;
  logic       HBlank;
  logic [2:0] Rx;
  logic [2:0] Gx;
  logic [2:0] Bx;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BL;
  logic [2:0] VGA_R;
  logic [2:0] VGA_G;
  logic [2:0] VGA_B;

  modport master (
    output HSync, VSync, HBlank, Rx, Gx, Bx,
    input  VGA_HS, VGA_VS, VGA_BL, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  HSync, VSync, HBlank, Rx, Gx, Bx,
    output VGA_HS, VGA_VS, VGA_BL, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/scandoubler_zx.sv
// ZX Spectrum scandoubler: buffers one ULA line per bank and replays it twice at ce_14m,
// or passes the ULA signals straight through (registered) when enable is low.
module scandoubler_zx #(
  parameter int unsigned HW = 9,
  parameter int unsigned DW = 9
) (
  input  logic            clk_sys,
  input  logic            nRESET,
  input  logic            ce_7mp,
  input  logic            ce_14m,
  input  logic            enable,
  scandoubler_zx_if.slave vid
);

  localparam logic [HW-1:0] XOne = HW'(1);
  localparam logic [HW-1:0] XMax = '1;

  typedef logic [DW:0] entry_t;

  // Two banks flattened into one array, addressed by {bank, x}.
  entry_t line_buf [2**(HW+1)];

  logic [HW-1:0] wr_x_q, wr_x_d;
  logic [HW-1:0] rd_x_q, rd_x_d;
  logic [HW-1:0] hlen_q, hlen_d;
  logic [HW-1:0] hs_cnt_q, hs_cnt_d;
  logic [HW-1:0] hs_w_q, hs_w_d;
  logic          bank_q, bank_d;
  logic          seen_q, seen_d;
  logic          valid_q, valid_d;
  logic          vs_lat_q, vs_lat_d;
  logic          hs_prev_q, hs_prev_d;
  logic          vga_hs_q, vga_hs_d;
  logic          vga_vs_q, vga_vs_d;
  logic          vga_bl_q, vga_bl_d;
  logic [8:0]    vga_rgb_q, vga_rgb_d;

  logic          hs_rise;
  logic          hlen_short;
  logic          wr_bank;
  logic [HW-1:0] wr_addr;
  entry_t        wr_data;
  entry_t        rd_data;

  assign hs_rise    = ce_7mp & vid.HSync & ~hs_prev_q;
  assign hlen_short = hlen_q < HW'(2);

  // The sample carrying the HSync rise opens the new line at pixel 0, so hlen
  // latched at the next rise spans the whole rise-to-rise period.
  assign wr_bank = hs_rise ? ~bank_q : bank_q;
  assign wr_addr = hs_rise ? '0 : wr_x_q;
  assign wr_data = entry_t'({vid.HBlank, vid.Rx, vid.Gx, vid.Bx});
  assign rd_data = line_buf[{~bank_q, rd_x_q}];

  always_ff @(posedge clk_sys) begin
    if (ce_7mp) begin
      line_buf[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  always_comb begin
    wr_x_d    = wr_x_q;
    rd_x_d    = rd_x_q;
    hlen_d    = hlen_q;
    hs_cnt_d  = hs_cnt_q;
    hs_w_d    = hs_w_q;
    bank_d    = bank_q;
    seen_d    = seen_q;
    valid_d   = valid_q;
    vs_lat_d  = vs_lat_q;
    hs_prev_d = hs_prev_q;
    vga_hs_d  = vga_hs_q;
    vga_vs_d  = vga_vs_q;
    vga_bl_d  = vga_bl_q;
    vga_rgb_d = vga_rgb_q;

    if (ce_7mp) begin
      hs_prev_d = vid.HSync;
      if (hs_rise) begin
        hlen_d   = wr_x_q;
        wr_x_d   = XOne;
        bank_d   = ~bank_q;
        vs_lat_d = vid.VSync;
        seen_d   = 1'b1;
        if (seen_q) begin
          valid_d = 1'b1;
        end
      end else if (wr_x_q != XMax) begin
        wr_x_d = wr_x_q + XOne;
      end

      if (vid.HSync) begin
        if (hs_rise) begin
          hs_cnt_d = XOne;
        end else if (hs_cnt_q != XMax) begin
          hs_cnt_d = hs_cnt_q + XOne;
        end
      end else if (hs_prev_q) begin
        hs_w_d = hs_cnt_q;
      end
    end

    // A new line restarts playback even when ce_14m lands in the same cycle.
    if (hs_rise) begin
      rd_x_d = '0;
    end else if (ce_14m) begin
      if (hlen_short || rd_x_q == hlen_q - XOne) begin
        rd_x_d = '0;
      end else begin
        rd_x_d = rd_x_q + XOne;
      end
    end

    if (!enable) begin
      if (ce_7mp) begin
        vga_hs_d  = vid.HSync;
        vga_vs_d  = vid.VSync;
        vga_bl_d  = vid.HBlank;
        vga_rgb_d = {vid.Rx, vid.Gx, vid.Bx};
      end
    end else if (ce_14m) begin
      vga_hs_d = rd_x_q < hs_w_q;
      vga_vs_d = vs_lat_q;
      if (!valid_q || hlen_short) begin
        vga_bl_d  = 1'b1;
        vga_rgb_d = '0;
      end else begin
        vga_bl_d  = rd_data[DW];
        vga_rgb_d = rd_data[DW] ? 9'd0 : rd_data[8:0];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      wr_x_q    <= '0;
      rd_x_q    <= '0;
      hlen_q    <= '0;
      hs_cnt_q  <= '0;
      hs_w_q    <= '0;
      bank_q    <= 1'b0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      vs_lat_q  <= 1'b0;
      hs_prev_q <= 1'b0;
      vga_hs_q  <= 1'b0;
      vga_vs_q  <= 1'b0;
      vga_bl_q  <= 1'b1;
      vga_rgb_q <= '0;
    end else begin
      wr_x_q    <= wr_x_d;
      rd_x_q    <= rd_x_d;
      hlen_q    <= hlen_d;
      hs_cnt_q  <= hs_cnt_d;
      hs_w_q    <= hs_w_d;
      bank_q    <= bank_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      vs_lat_q  <= vs_lat_d;
      hs_prev_q <= hs_prev_d;
      vga_hs_q  <= vga_hs_d;
      vga_vs_q  <= vga_vs_d;
      vga_bl_q  <= vga_bl_d;
      vga_rgb_q <= vga_rgb_d;
    end
  end

  assign vid.VGA_HS = vga_hs_q;
  assign vid.VGA_VS = vga_vs_q;
  assign vid.VGA_BL = vga_bl_q;
  assign vid.VGA_R  = vga_rgb_q[8:6];
  assign vid.VGA_G  = vga_rgb_q[5:3];
  assign vid.VGA_B  = vga_rgb_q[2:0];

endmodule

// File: tb/tb_scandoubler_zx.sv
// Bench for scandoubler_zx: line-level reference model checked every clk_sys, plus a
// bypass vector table and hand sequences for ZX48/ZX128 timing and mid-line reset.
module tb_scandoubler_zx;
  localparam int unsigned HW = 9;
  localparam int unsigned DW = 9;
  localparam int LineMax = 2**HW;

  logic clk_sys = 1'b0;
  logic nRESET;
  logic ce_7mp;
  logic ce_14m;
  logic enable;

  scandoubler_zx_if vid ();

  scandoubler_zx #(.HW(HW), .DW(DW)) dut (
    .clk_sys(clk_sys),
    .nRESET (nRESET),
    .ce_7mp (ce_7mp),
    .ce_14m (ce_14m),
    .enable (enable),
    .vid    (vid)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int hs_hi = 0;
  int nonblank = 0;
  logic vs_level;

  // Reference model: whole lines are captured, then copied out as the replay line.
  logic [DW:0] cur_line [LineMax];
  logic [DW:0] disp_line [LineMax];
  int cur_n, disp_len, pos, hs_run, hs_width, edges;
  logic hs_last, vs_lat;
  logic [11:0] exp_out;

  typedef struct packed {
    logic hs; logic vs; logic hb;
    logic [2:0] r; logic [2:0] g; logic [2:0] b;
    logic [11:0] want;
  } byp_vec_t;
  byp_vec_t tbl [6];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {vid.VGA_HS, vid.VGA_VS, vid.VGA_BL, vid.VGA_R, vid.VGA_G, vid.VGA_B};
  endfunction

  function automatic void model_reset();
    cur_n = 0; disp_len = 0; pos = 0; hs_run = 0; hs_width = 0; edges = 0;
    hs_last = 1'b0; vs_lat = 1'b0; exp_out = 12'h200;
  endfunction

  function automatic void model_step();
    logic rise;
    logic [DW:0] smp, px;
    if (!nRESET) begin
      model_reset();
      return;
    end
    rise = ce_7mp && vid.HSync && !hs_last;
    smp = {vid.HBlank, vid.Rx, vid.Gx, vid.Bx};
    if (!enable && ce_7mp) begin
      exp_out = {vid.HSync, vid.VSync, vid.HBlank, vid.Rx, vid.Gx, vid.Bx};
    end else if (enable && ce_14m) begin
      if (edges < 2 || disp_len < 2) begin
        exp_out = {(pos < hs_width), vs_lat, 1'b1, 9'd0};
      end else begin
        px = disp_line[pos];
        exp_out = {(pos < hs_width), vs_lat, px[DW], px[DW] ? 9'd0 : px[8:0]};
      end
    end
    if (rise) pos = 0;
    else if (ce_14m) pos = (disp_len < 2) ? 0 : (pos + 1) % disp_len;
    if (ce_7mp) begin
      if (rise) begin
        for (int i = 0; i < cur_n; i++) disp_line[i] = cur_line[i];
        disp_len = cur_n;
        cur_line[0] = smp;
        cur_n = 1;
        vs_lat = vid.VSync;
        edges++;
      end else begin
        cur_line[cur_n] = smp;
        if (cur_n < LineMax - 1) cur_n++;
      end
      if (vid.HSync) hs_run = hs_last ? ((hs_run < LineMax - 1) ? hs_run + 1 : hs_run) : 1;
      else if (hs_last) hs_width = hs_run;
      hs_last = vid.HSync;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("out", int'(dut_out()), int'(exp_out));
    if (ce_14m && vid.VGA_HS) hs_hi++;
    if (!vid.VGA_BL) nonblank++;
  endtask

  // One ULA pixel: ce_7mp+ce_14m, idle, ce_14m, idle, then optional extra idle cycles.
  task automatic drive_pixel(input logic hs, input logic vs, input logic hb,
                             input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                             input int idle);
    logic rise;
    vid.HSync = hs; vid.VSync = vs; vid.HBlank = hb;
    vid.Rx = r; vid.Gx = g; vid.Bx = b;
    rise = hs && !hs_last && nRESET;
    ce_7mp = 1'b1; ce_14m = 1'b1;
    tick();
    if (rise) check("rd_x_after_rise", int'(dut.rd_x_q), 0);
    ce_7mp = 1'b0; ce_14m = 1'b0;
    tick();
    ce_14m = 1'b1;
    tick();
    ce_14m = 1'b0;
    tick();
    for (int k = 0; k < idle; k++) tick();
  endtask

  task automatic zx_pixels(input int from, input int upto, input bit ramp);
    for (int i = from; i < upto; i++) begin
      logic [8:0] d;
      d = ramp ? 9'(i) : 9'($urandom);
      drive_pixel(i >= 336 && i < 368, vs_level, i >= 320 && i < 416,
                  d[8:6], d[5:3], d[2:0], 0);
    end
  endtask

  task automatic rand_line();
    int len, hs0, hsl;
    logic v;
    len = $urandom_range(160, 2);
    hs0 = $urandom_range(len - 1, 1);
    hsl = $urandom_range(len - hs0, 1);
    v = 1'($urandom_range(1, 0));
    enable = ($urandom_range(3, 0) != 0);
    for (int i = 0; i < len; i++) begin
      logic [8:0] d;
      d = 9'($urandom);
      drive_pixel(i >= hs0 && i < hs0 + hsl, v, ($urandom_range(3, 0) == 0),
                  d[8:6], d[5:3], d[2:0], ($urandom_range(7, 0) == 0) ? 1 : 0);
    end
  endtask

  initial begin
    tbl[0] = {1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 3'b000, 12'b000_101_000_000};
    tbl[1] = {1'b1, 1'b0, 1'b0, 3'b010, 3'b111, 3'b001, 12'b100_010_111_001};
    tbl[2] = {1'b1, 1'b1, 1'b1, 3'b111, 3'b111, 3'b111, 12'b111_111_111_111};
    tbl[3] = {1'b0, 1'b1, 1'b0, 3'b000, 3'b011, 3'b110, 12'b010_000_011_110};
    tbl[4] = {1'b0, 1'b0, 1'b1, 3'b100, 3'b010, 3'b001, 12'b001_100_010_001};
    tbl[5] = {1'b1, 1'b0, 1'b1, 3'b001, 3'b100, 3'b011, 12'b101_001_100_011};

    nRESET = 1'b0; ce_7mp = 1'b0; ce_14m = 1'b0; enable = 1'b1; vs_level = 1'b0;
    vid.HSync = 1'b0; vid.VSync = 1'b0; vid.HBlank = 1'b0;
    vid.Rx = '0; vid.Gx = '0; vid.Bx = '0;
    model_reset();
    repeat (3) tick();
    check("reset_state", int'(dut_out()), 12'h200);
    nRESET = 1'b1;

    // ZX48 lines with a pixel ramp; the last line measures HS duty in steady state.
    repeat (3) zx_pixels(0, 448, 1'b1);
    hs_hi = 0;
    vs_level = 1'b1;
    zx_pixels(0, 448, 1'b1);
    check("hs_hi_two_out_lines", hs_hi, 64);
    check("hlen_zx48", int'(dut.hlen_q), 448);
    check("hs_w_zx48", int'(dut.hs_w_q), 32);

    // ZX128 lines following ZX48.
    vs_level = 1'b0;
    repeat (2) zx_pixels(0, 456, 1'b1);
    check("hlen_zx128", int'(dut.hlen_q), 456);
    zx_pixels(0, 456, 1'b1);

    // Reset in the middle of a line.
    zx_pixels(0, 200, 1'b1);
    nRESET = 1'b0;
    #1;
    check("reset_async", int'(dut_out()), 12'h200);
    model_reset();
    repeat (2) tick();
    nRESET = 1'b1;
    nonblank = 0;
    zx_pixels(200, 448, 1'b1);
    zx_pixels(0, 337, 1'b1);
    check("blank_until_2nd_rise", nonblank, 0);
    zx_pixels(337, 448, 1'b1);
    zx_pixels(0, 448, 1'b1);
    check("nonblank_after_valid", int'(nonblank > 0), 1);

    // Bypass vectors.
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_pixel(tbl[k].hs, tbl[k].vs, tbl[k].hb, tbl[k].r, tbl[k].g, tbl[k].b, 0);
      check("bypass_vec", int'(dut_out()), int'(tbl[k].want));
    end
    enable = 1'b1;

    repeat (30) rand_line();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
